// File: rtl/stack_seq_pkg.sv
// Shared opcodes, sequencer states and default widths for the operand-stack sequencer.
package stack_seq_pkg;

  localparam int STK_DW = 35;
  localparam int STK_AW = 11;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_PUSHI = 4'd1,
    OP_DROP  = 4'd2,
    OP_POPN  = 4'd3,
    OP_DUP   = 4'd4,
    OP_SWAP  = 4'd5,
    OP_ADD   = 4'd8,
    OP_SUB   = 4'd9,
    OP_AND   = 4'd10,
    OP_OR    = 4'd11,
    OP_XOR   = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_PUSH1 = 2'd2,
    ST_PUSH2 = 2'd3
  } state_e;

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational B-op-A for the binary stack ops (B = second entry, A = top).
// Zero latency; no flow control, results are modulo 2^DW.
module stack_seq_alu
  import stack_seq_pkg::*;
#(
  parameter int DW = STK_DW
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = b + a;
      OP_SUB:  y = b - a;
      OP_AND:  y = b & a;
      OP_OR:   y = b | a;
      OP_XOR:  y = b ^ a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/stack_seq.sv
// Turns one stack-machine op per handshake into pop-then-push cycles for the operand stack.
// Done 1-4 cycles after accept; in_ready holds off until the stack's 2-cycle top lag has settled.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int DW = STK_DW,
  parameter int AW = STK_AW
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_imm,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] depth,
  output logic          st__pop,
  output logic          st__push,
  output logic [AW-1:0] st__to_pop,
  output logic [DW-1:0] st__to_push,
  input  logic [DW-1:0] st__top_0,
  input  logic [DW-1:0] st__top_1
);

  localparam logic [AW-1:0] MAX_DEPTH = '1;

  state_e        state;
  logic [1:0]    settle;
  logic [DW-1:0] d1_q, d2_q;
  logic [1:0]    npush_q;

  logic          dec_ok, dec_pop;
  logic [AW-1:0] dec_n;
  logic [1:0]    dec_npush;
  logic [DW-1:0] dec_d1, dec_d2;
  logic [DW-1:0] alu_y;
  logic [AW-1:0] cnt;

  assign cnt      = in_imm[AW-1:0];
  assign in_ready = (state == ST_IDLE) && (settle == 2'd0);

  stack_seq_alu #(.DW(DW)) u_alu (
    .op (in_op),
    .a  (st__top_0),
    .b  (st__top_1),
    .y  (alu_y)
  );

  // Everything needed later (push data, pop count) is captured at accept,
  // so the stack tops are free to change once traffic starts.
  always_comb begin
    dec_ok    = 1'b1;
    dec_pop   = 1'b0;
    dec_n     = '0;
    dec_npush = 2'd0;
    dec_d1    = '0;
    dec_d2    = '0;
    case (in_op)
      OP_PUSHI: begin
        dec_ok    = (depth != MAX_DEPTH);
        dec_npush = 2'd1;
        dec_d1    = in_imm;
      end
      OP_DROP: begin
        dec_ok  = (depth != '0);
        dec_pop = 1'b1;
        dec_n   = AW'(1);
      end
      OP_POPN: begin
        dec_ok  = (depth >= cnt);
        dec_pop = (cnt != '0);
        dec_n   = cnt;
      end
      OP_DUP: begin
        dec_ok    = (depth != '0) && (depth != MAX_DEPTH);
        dec_npush = 2'd1;
        dec_d1    = st__top_0;
      end
      OP_SWAP: begin
        dec_ok    = (depth >= AW'(2));
        dec_pop   = 1'b1;
        dec_n     = AW'(2);
        dec_npush = 2'd2;
        dec_d1    = st__top_0;
        dec_d2    = st__top_1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        dec_ok    = (depth >= AW'(2));
        dec_pop   = 1'b1;
        dec_n     = AW'(2);
        dec_npush = 2'd1;
        dec_d1    = alu_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= ST_IDLE;
      settle      <= 2'd0;
      depth       <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      st__pop     <= 1'b0;
      st__push    <= 1'b0;
      st__to_pop  <= '0;
      st__to_push <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      npush_q     <= 2'd0;
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      st__pop     <= 1'b0;
      st__push    <= 1'b0;
      st__to_pop  <= '0;
      st__to_push <= '0;

      if (st__pop || st__push)
        settle <= 2'd2;
      else if (settle != 2'd0)
        settle <= settle - 2'd1;

      // Tracks the stack's sp on the same edge it moves.
      if (st__pop)
        depth <= depth - st__to_pop;
      else if (st__push)
        depth <= depth + AW'(1);

      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            d1_q    <= dec_d1;
            d2_q    <= dec_d2;
            npush_q <= dec_npush;
            if (!dec_ok) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (dec_pop) begin
              state      <= ST_POP;
              st__pop    <= 1'b1;
              st__to_pop <= dec_n;
            end else if (dec_npush != 2'd0) begin
              state       <= ST_PUSH1;
              st__push    <= 1'b1;
              st__to_push <= dec_d1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_POP: begin
          if (npush_q != 2'd0) begin
            state       <= ST_PUSH1;
            st__push    <= 1'b1;
            st__to_push <= d1_q;
          end else begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        ST_PUSH1: begin
          if (npush_q == 2'd2) begin
            state       <= ST_PUSH2;
            st__push    <= 1'b1;
            st__to_push <= d2_q;
          end else begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        ST_PUSH2: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: operand-stack stand-in plus a queue-based op-semantics reference.
module tb_stack_seq;

  localparam int DW   = 35;
  localparam int AW   = 11;
  localparam int MAXD = 2047;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [DW-1:0] in_imm;
  logic          done;
  logic          err;
  logic [AW-1:0] depth;
  logic          st__pop;
  logic          st__push;
  logic [AW-1:0] st__to_pop;
  logic [DW-1:0] st__to_push;
  logic [DW-1:0] st__top_0;
  logic [DW-1:0] st__top_1;

  always #5 clk = ~clk;

  stack_seq #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_imm      (in_imm),
    .done        (done),
    .err         (err),
    .depth       (depth),
    .st__pop     (st__pop),
    .st__push    (st__push),
    .st__to_pop  (st__to_pop),
    .st__to_push (st__to_push),
    .st__top_0   (st__top_0),
    .st__top_1   (st__top_1)
  );

  // Operand stack stand-in: tops are registered twice after sp/mem move.
  logic [DW-1:0] mem [0:MAXD];
  int            sp;
  logic [DW-1:0] p0, p1;

  always @(posedge clk) begin
    if (!rst_b) begin
      sp <= 0;
      p0 <= '0;
      p1 <= '0;
      st__top_0 <= '0;
      st__top_1 <= '0;
    end else begin
      if (st__pop)
        sp <= (sp >= int'(st__to_pop)) ? sp - int'(st__to_pop) : 0;
      else if (st__push && sp <= MAXD) begin
        mem[sp] <= st__to_push;
        sp <= sp + 1;
      end
      p0 <= (sp >= 1) ? mem[sp-1] : '0;
      p1 <= (sp >= 2) ? mem[sp-2] : '0;
      st__top_0 <= p0;
      st__top_1 <= p1;
    end
  end

  int errors = 0;
  int checks = 0;
  int viol = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Interface rules that must hold every cycle.
  always @(negedge clk) begin
    if (rst_b) begin
      if (st__pop && st__push) viol++;
      if (!st__pop && st__to_pop != '0) viol++;
      if (!st__push && st__to_push != '0) viol++;
      if (err && !done) viol++;
    end
  end

  logic [DW-1:0] q[$];

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [DW-1:0] imm, input bit chk_top);
    logic [DW+1:0] exp_ev[$];
    logic [DW+1:0] got_ev[$];
    logic [DW-1:0] a, b, r;
    int            exp_lat, sz, n, lat, w;
    bit            exp_err;

    sz      = q.size();
    exp_err = 1'b0;
    exp_lat = 1;
    a = (sz >= 1) ? q[sz-1] : '0;
    b = (sz >= 2) ? q[sz-2] : '0;
    case (op)
      4'd1: if (sz < MAXD) begin
              q.push_back(imm);
              exp_ev.push_back({2'b10, imm});
              exp_lat = 2;
            end else exp_err = 1'b1;
      4'd2: if (sz >= 1) begin
              void'(q.pop_back());
              exp_ev.push_back({2'b01, DW'(1)});
              exp_lat = 2;
            end else exp_err = 1'b1;
      4'd3: begin
              n = int'(imm[AW-1:0]);
              if (n > sz) exp_err = 1'b1;
              else if (n > 0) begin
                repeat (n) void'(q.pop_back());
                exp_ev.push_back({2'b01, DW'(n)});
                exp_lat = 2;
              end
            end
      4'd4: if (sz >= 1 && sz < MAXD) begin
              q.push_back(a);
              exp_ev.push_back({2'b10, a});
              exp_lat = 2;
            end else exp_err = 1'b1;
      4'd5: if (sz >= 2) begin
              void'(q.pop_back());
              void'(q.pop_back());
              q.push_back(a);
              q.push_back(b);
              exp_ev.push_back({2'b01, DW'(2)});
              exp_ev.push_back({2'b10, a});
              exp_ev.push_back({2'b10, b});
              exp_lat = 4;
            end else exp_err = 1'b1;
      4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
            if (sz >= 2) begin
              case (op)
                4'd8:    r = b + a;
                4'd9:    r = b - a;
                4'd10:   r = b & a;
                4'd11:   r = b | a;
                default: r = b ^ a;
              endcase
              void'(q.pop_back());
              void'(q.pop_back());
              q.push_back(r);
              exp_ev.push_back({2'b01, DW'(2)});
              exp_ev.push_back({2'b10, r});
              exp_lat = 3;
            end else exp_err = 1'b1;
      default: ;
    endcase

    // Offer the op and hold it until the sequencer is ready.
    in_valid = 1'b1;
    in_op    = op;
    in_imm   = imm;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (chk_top && sz >= 1) chk("top0", 64'(st__top_0), 64'(a));
    if (chk_top && sz >= 2) chk("top1", 64'(st__top_1), 64'(b));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!done && lat < 8) begin
      if (st__pop)  got_ev.push_back({2'b01, DW'(st__to_pop)});
      if (st__push) got_ev.push_back({2'b10, st__to_push});
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("err", 64'(err), 64'(exp_err));
    chk("traffic_count", 64'(got_ev.size()), 64'(exp_ev.size()));
    foreach (exp_ev[i])
      if (i < got_ev.size()) chk("traffic", 64'(got_ev[i]), 64'(exp_ev[i]));
    chk("depth", 64'(depth), 64'(q.size()));
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    q.delete();
  endtask

  logic [3:0] op_tbl [0:15];

  initial begin
    op_tbl = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4,
               4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd6, 4'd14};
    rst_b    = 1'b0;
    in_valid = 1'b0;
    in_op    = '0;
    in_imm   = '0;
    repeat (3) @(negedge clk);
    chk("rst_depth", 64'(depth), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_pop", 64'(st__pop), 64'd0);
    chk("rst_push", 64'(st__push), 64'd0);
    chk("rst_to_pop", 64'(st__to_pop), 64'd0);
    chk("rst_to_push", 64'(st__to_push), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    rst_b = 1'b1;
    @(negedge clk);

    do_op(4'd1, DW'(5), 1'b1);
    do_op(4'd1, DW'(7), 1'b1);
    do_op(4'd8, '0, 1'b1);
    do_op(4'd0, '0, 1'b1);

    reset_dut();
    do_op(4'd1, DW'(3), 1'b1);
    do_op(4'd1, DW'(10), 1'b1);
    do_op(4'd9, '0, 1'b1);
    do_op(4'd0, '0, 1'b1);

    reset_dut();
    do_op(4'd1, DW'(1), 1'b1);
    do_op(4'd1, DW'(2), 1'b1);
    do_op(4'd5, '0, 1'b1);
    do_op(4'd0, '0, 1'b1);

    reset_dut();
    do_op(4'd8, '0, 1'b1);
    do_op(4'd2, '0, 1'b1);
    do_op(4'd3, DW'(1), 1'b1);

    // Fill to the depth limit, probe overflow, then drain in one pop.
    reset_dut();
    for (int i = 0; i < MAXD; i++) do_op(4'd1, rnd_word(), 1'b0);
    do_op(4'd1, rnd_word(), 1'b1);
    do_op(4'd4, '0, 1'b1);
    do_op(4'd3, DW'(MAXD), 1'b1);

    reset_dut();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = op_tbl[$urandom_range(0, 15)];
      if (op == 4'd3) do_op(op, DW'($urandom_range(0, 4)), 1'b1);
      else            do_op(op, rnd_word(), 1'b1);
    end

    // Reset landing in the PUSH1 cycle of a SWAP.
    reset_dut();
    do_op(4'd1, DW'(1), 1'b1);
    do_op(4'd1, DW'(2), 1'b1);
    in_valid = 1'b1;
    in_op    = 4'd5;
    in_imm   = '0;
    for (int w = 0; w < 20 && !in_ready; w++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("swap_pop", 64'(st__pop), 64'd1);
    chk("swap_to_pop", 64'(st__to_pop), 64'd2);
    @(negedge clk);
    chk("swap_push1", 64'(st__push), 64'd1);
    chk("swap_push1_dat", 64'(st__to_push), 64'd2);
    rst_b = 1'b0;
    @(negedge clk);
    chk("abort_push", 64'(st__push), 64'd0);
    chk("abort_pop", 64'(st__pop), 64'd0);
    chk("abort_to_push", 64'(st__to_push), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_depth", 64'(depth), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    rst_b = 1'b1;
    q.delete();
    @(negedge clk);
    do_op(4'd1, DW'(9), 1'b1);
    do_op(4'd0, '0, 1'b1);

    chk("protocol_violations", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Command sequencer that drives the st__ push/pop interface of the CPU operand stack and consumes its registered top-of-stack outputs.
- Accepts one stack-machine operation per handshake: immediate push, drop, pop-N, dup, swap, and binary ALU ops.
- Converts each operation into the legal pop-then-push cycle sequence the stack requires. The stack cannot pop and push in the same cycle, and its tops lag any update by 2 cycles.
- Tracks stack depth, rejects underflow and overflow, and sits between the instruction decoder and the operand stack.

Parameters:
DW, 35, stack word width (matches stack entry)
AW, 11, stack pointer width; maximum depth = 2^AW - 1 = 2047

Ports:
clk  in  1  clock
rst_b  in  1  reset, synchronous, active-low (same rst_b that resets the stack's sp)
in_valid  in  1  operation offered
in_ready  out  1  sequencer can accept an operation this cycle
in_op  in  4  opcode (see defs)
in_imm  in  DW  immediate for PUSHI; [AW-1:0] is the count for POPN
done  out  1  one-cycle pulse: operation retired
err  out  1  one-cycle pulse coincident with done: operation rejected
depth  out  AW  current stack depth
st__pop  out  1  to stack: pop st__to_pop entries
st__push  out  1  to stack: push st__to_push
st__to_pop  out  AW  to stack: pop count
st__to_push  out  DW  to stack: push data
st__top_0  in  DW  from stack: top entry (registered, valid 2 cycles after last update)
st__top_1  in  DW  from stack: second entry

Behaviour:
- Reset (rst_b low at posedge): state=IDLE, settle=0, depth=0, and done, err, st__pop, st__push, st__to_pop, st__to_push all 0. Reset has priority over everything and aborts any in-flight op with no further stack traffic.
- Settle counter (2 bits):
  - Loaded with 2 on every cycle st__pop or st__push is high, otherwise decrements to 0.
  - in_ready = (state==IDLE) && (settle==0).
- Accept: on the edge where in_valid && in_ready:
  - Latch opcode and immediate.
  - Latch A=st__top_0 and B=st__top_1.
  - Check depth needs: DROP/DUP need 1; SWAP/ALU need 2; POPN needs imm[AW-1:0]; PUSHI and DUP need depth < 2047.
- Rejected op: next cycle done=1 and err=1, with no stack traffic and depth unchanged.
- NOP, or POPN with count 0: next cycle done=1, no traffic.
- States (Moore; stack outputs decode from registered state, one cycle each):
  - IDLE
  - POP: st__pop=1, st__to_pop=n
  - PUSH1: st__push=1, st__to_push=d1
  - PUSH2: st__push=1, st__to_push=d2
  - After the last state return to IDLE. done pulses in the cycle after the last stack-update cycle.
- Sequences:
  - PUSHI: PUSH1(imm)
  - DROP: POP(1)
  - POPN: POP(imm)
  - DUP: PUSH1(A)
  - SWAP: POP(2), PUSH1(A), PUSH2(B)
  - ADD/SUB/AND/OR/XOR: POP(2), PUSH1(B op A)
- Arithmetic: SUB is B-A (second minus top). All ops are full-DW modulo 2^DW with no flags.
- Output registers: st__pop and st__push are never high together. st__to_pop and st__to_push are 0 when not in their state.
- depth updates on the same edge the stack updates sp: -n for POP, +1 for each PUSH.
- Latency from accept edge to done pulse: 1 cycle for NOP/reject; 2 for PUSHI/DROP/POPN/DUP; 3 for ALU; 4 for SWAP. Next in_ready rises 2 cycles after the last stack-update cycle.
- in_valid while not ready is ignored; the offering side must hold the op.

Decomposition:
- stack_seq_defs.vh holds:
  - opcodes: NOP=0, PUSHI=1, DROP=2, POPN=3, DUP=4, SWAP=5, ADD=8, SUB=9, AND=10, OR=11, XOR=12; others are treated as NOP.
  - state encodings IDLE/POP/PUSH1/PUSH2
  - MAX_DEPTH
- Sub-module stack_seq_alu: combinational B op A for the five ALU opcodes.

Test Plan:
- Reset, then PUSHI 5, PUSHI 7, ADD -> 2 pushes, pop(2), push 12; depth=1; st__top_0=12 after settle.
- PUSHI 3, PUSHI 10, SUB -> pushed value 35'h7FFFFFFF9 (3-10 wrap); err never high.
- PUSHI 1, PUSHI 2, SWAP -> st__to_pop=2 for one cycle, then pushes of 2 then 1; tops 1/2; done 4 cycles after accept.
- After reset: ADD, DROP, POPN imm=1 -> each gives done+err 1 cycle after accept; st__pop/st__push stay 0; depth=0.
- 2047 PUSHI then another PUSHI -> err; depth=2047; no st__push. Then POPN 2047 -> depth=0.
- Drop rst_b low in the PUSH1 cycle of SWAP -> next cycle all outputs 0, depth=0, in_ready=1.
